uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_shift_reg.sv | 22 ++
 rtl/uart_tx_engine.sv | 89 ++++++++
 tb/tb_uart_tx_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: state encoding and frame geometry.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    localparam int FRAME_LEN = 11;
    localparam int BCNT_W    = 4;

endpackage

// File: rtl/uart_tx_shift_reg.sv
// 11-bit parallel-load / shift-right register; vacated MSB fills with 1 so the line returns to idle.
module uart_tx_shift_reg
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [FRAME_LEN-1:0] din,
    output logic [FRAME_LEN-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '1;
        else if (load)
            q <= din;
        else if (shift)
            q <= {1'b1, q[FRAME_LEN-1:1]};
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: assembles a start/data/parity/stop frame and shifts it out LSB first on BTU.
module uart_tx_engine
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       LOAD,
    input  logic [7:0] OUT_PORT,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       BTU,
    output logic       DOIT,
    output logic       TX,
    output logic       TXRDY
);

    tx_state_e             state, next_state;
    logic [BCNT_W-1:0]     bit_count;
    logic [FRAME_LEN-1:0]  frame, sr_q;
    logic                  load_en, shift_en, last_bit;
    logic                  p8, p7;

    assign p8 = ^OUT_PORT ^ OHEL;
    assign p7 = ^OUT_PORT[6:0] ^ OHEL;

    always_comb begin
        frame = '1;
        case ({EIGHT, PEN})
            2'b11:   frame = {1'b1, p8,   OUT_PORT[7:0], 1'b0};
            2'b10:   frame = {1'b1, 1'b1, OUT_PORT[7:0], 1'b0};
            2'b01:   frame = {1'b1, 1'b1, p7,   OUT_PORT[6:0], 1'b0};
            default: frame = {1'b1, 1'b1, 1'b1, OUT_PORT[6:0], 1'b0};
        endcase
    end

    // The eleventh bit time ends on the BTU seen while bit_count reads 10.
    assign last_bit = BTU && (bit_count == BCNT_W'(FRAME_LEN - 1));

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD) begin
                    load_en    = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                shift_en = BTU;
                if (last_bit)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bit_count <= '0;
        else if (load_en)
            bit_count <= '0;
        else if (shift_en)
            bit_count <= bit_count + 1'b1;
    end

    uart_tx_shift_reg u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (load_en),
        .shift (shift_en),
        .din   (frame),
        .q     (sr_q)
    );

    assign TX    = sr_q[0];
    assign DOIT  = (state == SEND);
    assign TXRDY = (state == IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine with a BTU stub and a bit-list frame model.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       LOAD;
    logic [7:0] OUT_PORT;
    logic       EIGHT, PEN, OHEL;
    logic       BTU;
    logic       DOIT, TX, TXRDY;
    logic       btu_stub = 1'b0;
    logic       btu_idle = 1'b0;
    int         stub_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign BTU = btu_stub | btu_idle;

    uart_tx_engine dut (
        .clk      (clk),
        .reset    (reset),
        .LOAD     (LOAD),
        .OUT_PORT (OUT_PORT),
        .EIGHT    (EIGHT),
        .PEN      (PEN),
        .OHEL     (OHEL),
        .BTU      (BTU),
        .DOIT     (DOIT),
        .TX       (TX),
        .TXRDY    (TXRDY)
    );

    always #5 clk = ~clk;

    // BTU stub: one-cycle pulse every fourth cycle while DOIT is high.
    always @(negedge clk) begin
        if (DOIT !== 1'b1) begin
            stub_cnt = 0;
            btu_stub = 1'b0;
        end else if (stub_cnt == 3) begin
            stub_cnt = 0;
            btu_stub = 1'b1;
        end else begin
            stub_cnt++;
            btu_stub = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Line order: start bit, n data bits LSB first, optional parity, then ones.
    function automatic logic [10:0] model_frame(logic [7:0] d, logic e, logic p, logic o);
        logic [10:0] f;
        int n, ones, pos;
        f    = '1;
        n    = e ? 8 : 7;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        pos = 1 + n;
        if (p) f[pos] = ((ones % 2) == 1) ^ o;
        return f;
    endfunction

    // Starts a frame at the current cycle and records one TX value per bit time.
    task automatic run_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                             input int inject_bit, input bit drop_end,
                             output logic [10:0] got, output int bad_status,
                             output int unstable, output bit timeout);
        int i, cyc, n;
        got = '1; bad_status = 0; unstable = 0; timeout = 1'b0;
        LOAD = 1'b1; OUT_PORT = d; EIGHT = e; PEN = p; OHEL = o;
        step();
        LOAD = 1'b0;
        OUT_PORT = 8'($urandom); EIGHT = 1'($urandom); PEN = 1'($urandom); OHEL = 1'($urandom);
        i = 0; cyc = 0; n = 0;
        forever begin
            if (DOIT !== 1'b1 || TXRDY !== 1'b0) bad_status++;
            if (cyc == 0) got[i] = TX;
            else if (TX !== got[i]) unstable++;
            LOAD = (i == inject_bit && cyc == 0);
            if (LOAD) OUT_PORT = 8'hAA;
            if (BTU === 1'b1) begin
                if (i == 10) begin
                    LOAD = drop_end;
                    step();
                    LOAD = 1'b0;
                    break;
                end
                i++;
                cyc = 0;
            end else begin
                cyc++;
            end
            n++;
            if (n > 200) begin
                timeout = 1'b1;
                LOAD = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; LOAD = 1'b0; OUT_PORT = 8'h00; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        #1;
        n_checks++; if (TX !== 1'b1)    begin n_fail++; $display("FAIL reset_tx got=%b exp=1", TX); end
        n_checks++; if (TXRDY !== 1'b1) begin n_fail++; $display("FAIL reset_txrdy got=%b exp=1", TXRDY); end
        n_checks++; if (DOIT !== 1'b0)  begin n_fail++; $display("FAIL reset_doit got=%b exp=0", DOIT); end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_btu_idle();
        for (int k = 0; k < 3; k++) begin
            btu_idle = 1'b1;
            step();
            n_checks++;
            if (TX !== 1'b1 || TXRDY !== 1'b1 || DOIT !== 1'b0) begin
                n_fail++; $display("FAIL btu_idle got tx=%b rdy=%b doit=%b exp 1 1 0", TX, TXRDY, DOIT);
            end
        end
        btu_idle = 1'b0;
        step();
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic e,
                              input logic p, input logic o);
        logic [10:0] got, exp;
        int bad, unst;
        bit to;
        exp = model_frame(d, e, p, o);
        run_frame(d, e, p, o, -1, 1'b0, got, bad, unst, to);
        n_checks++; if (to)        begin n_fail++; $display("FAIL %s timeout got=1 exp=0", name); end
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL %s frame got=%b exp=%b", name, got, exp); end
        n_checks++; if (bad != 0)  begin n_fail++; $display("FAIL %s status_in_frame got=%0d exp=0", name, bad); end
        n_checks++; if (unst != 0) begin n_fail++; $display("FAIL %s bit_unstable got=%0d exp=0", name, unst); end
        n_checks++;
        if (TXRDY !== 1'b1 || DOIT !== 1'b0 || TX !== 1'b1) begin
            n_fail++; $display("FAIL %s end got rdy=%b doit=%b tx=%b exp 1 0 1", name, TXRDY, DOIT, TX);
        end
    endtask

    task automatic test_parity_odd();
        logic [10:0] got;
        int bad, unst;
        bit to;
        run_frame(8'h55, 1'b1, 1'b1, 1'b1, -1, 1'b0, got, bad, unst, to);
        n_checks++; if (got[9] !== 1'b1) begin n_fail++; $display("FAIL odd_parity_bit got=%b exp=1", got[9]); end
        n_checks++;
        if (got !== 11'b110_1010_1010) begin
            n_fail++; $display("FAIL odd_parity_frame got=%b exp=%b", got, 11'b110_1010_1010);
        end
        step();
    endtask

    task automatic test_load_ignored();
        logic [10:0] got, exp;
        int bad, unst;
        bit to;
        exp = model_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        run_frame(8'h0F, 1'b1, 1'b0, 1'b0, 4, 1'b1, got, bad, unst, to);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL busy_load frame got=%b exp=%b", got, exp); end
        n_checks++; if (bad != 0)    begin n_fail++; $display("FAIL busy_load status got=%0d exp=0", bad); end
        n_checks++;
        if (TXRDY !== 1'b1 || DOIT !== 1'b0 || TX !== 1'b1) begin
            n_fail++; $display("FAIL end_load_dropped got rdy=%b doit=%b tx=%b exp 1 0 1", TXRDY, DOIT, TX);
        end
        exp = model_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        run_frame(8'hC3, 1'b1, 1'b1, 1'b1, -1, 1'b0, got, bad, unst, to);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL next_cycle_load frame got=%b exp=%b", got, exp); end
        n_checks++; if (to)          begin n_fail++; $display("FAIL next_cycle_load timeout got=1 exp=0"); end
        step();
    endtask

    task automatic test_reset_midframe();
        logic [10:0] got, exp;
        int bad, unst;
        bit to;
        LOAD = 1'b1; OUT_PORT = 8'h00; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        step();
        LOAD = 1'b0;
        repeat (21) step();
        n_checks++;
        if (TX !== 1'b0 || DOIT !== 1'b1) begin
            n_fail++; $display("FAIL midframe_pre got tx=%b doit=%b exp 0 1", TX, DOIT);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (TX !== 1'b1 || TXRDY !== 1'b1 || DOIT !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset got tx=%b rdy=%b doit=%b exp 1 1 0", TX, TXRDY, DOIT);
        end
        step();
        reset = 1'b0;
        exp = 11'b100_0000_0000;
        run_frame(8'h00, 1'b1, 1'b1, 1'b0, -1, 1'b0, got, bad, unst, to);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL after_reset frame got=%b exp=%b", got, exp); end
        n_checks++; if (bad != 0)    begin n_fail++; $display("FAIL after_reset status got=%0d exp=0", bad); end
        step();
    endtask

    task automatic test_random();
        logic [10:0] got, exp;
        logic [7:0] d;
        logic e, p, o;
        int bad, unst;
        bit to;
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom); e = 1'($urandom); p = 1'($urandom); o = 1'($urandom);
            exp = model_frame(d, e, p, o);
            run_frame(d, e, p, o, -1, 1'b0, got, bad, unst, to);
            n_checks++;
            if (got !== exp || bad != 0 || unst != 0 || to) begin
                n_fail++;
                $display("FAIL random[%0d] d=%h e=%b p=%b o=%b got=%b exp=%b bad=%0d unst=%0d to=%b",
                         k, d, e, p, o, got, exp, bad, unst, to);
            end
            n_checks++;
            if (TX !== 1'b1 || TXRDY !== 1'b1) begin
                n_fail++; $display("FAIL random_gap[%0d] got tx=%b rdy=%b exp 1 1", k, TX, TXRDY);
            end
            repeat ($urandom_range(2, 0)) step();
        end
    endtask

    initial begin
        test_reset();
        test_btu_idle();
        test_frame("even_55", 8'h55, 1'b1, 1'b1, 1'b0);
        step();
        test_parity_odd();
        test_frame("seven_41", 8'h41, 1'b0, 1'b0, 1'b0);
        step();
        test_load_ignored();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
